// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-buffer write port bundle
interface imem_loader_if #(
    parameter int i_adr_width   = 10,
    parameter int i_width       = 23,
    parameter int i_buffer_size = 2
);
    localparam int W = i_buffer_size * i_width;

    logic [7:0]             in_byte;
    logic                   in_valid;
    logic                   in_ready;
    logic [i_adr_width-1:0] imem_write_adr;
    logic                   imem_write;
    logic [W-1:0]           imem_in;
    logic                   load_busy;
    logic                   load_done;
    logic                   load_error;

    // loader side: consumes the byte stream, drives the buffer write port and status
    modport slave (
        input  in_byte, in_valid,
        output in_ready, imem_write_adr, imem_write, imem_in,
        output load_busy, load_done, load_error
    );

    // host / buffer side
    modport master (
        output in_byte, in_valid,
        input  in_ready, imem_write_adr, imem_write, imem_in,
        input  load_busy, load_done, load_error
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream program loader feeding the instruction buffer
module imem_loader #(
    parameter int         i_adr_width   = 10,
    parameter int         i_width       = 23,
    parameter int         i_buffer_size = 2,
    parameter logic [7:0] sync_byte     = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int W     = i_buffer_size * i_width;
    localparam int BPW   = (W + 7) / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADR_LO, S_ADR_HI, S_CNT_LO, S_CNT_HI,
        S_DATA, S_WRITE, S_CSUM, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_ready;
    logic                   accept;
    logic [7:0]             adr_lo_q;
    logic [i_adr_width-1:0] adr_q;
    logic [15:0]            cnt_q;
    logic [7:0]             csum_q;
    logic [IDX_W-1:0]       idx_q;
    logic [8*BPW-1:0]       asm_q, asm_d;
    logic [i_adr_width-1:0] write_adr_q;
    logic                   write_q;
    logic [W-1:0]           write_data_q;
    logic                   error_q;

    // the loader stalls the host only while it is busy emitting a write or the done pulse
    assign in_ready = (state_q != S_WRITE) && (state_q != S_DONE);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready       = in_ready;
    assign bus.imem_write_adr = write_adr_q;
    assign bus.imem_write     = write_q;
    assign bus.imem_in        = write_data_q;
    assign bus.load_busy      = (state_q != S_IDLE);
    assign bus.load_done      = (state_q == S_DONE);
    assign bus.load_error     = error_q;

    // group assembly: the incoming byte lands at its slot on top of the bytes gathered so far
    always_comb begin
        asm_d = asm_q;
        asm_d[{idx_q, 3'b000} +: 8] = bus.in_byte;
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic: header fields, payload groups, then checksum
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept && bus.in_byte == sync_byte) state_d = S_ADR_LO;
            S_ADR_LO: if (accept) state_d = S_ADR_HI;
            S_ADR_HI: if (accept) state_d = S_CNT_LO;
            S_CNT_LO: if (accept) state_d = S_CNT_HI;
            S_CNT_HI: if (accept) state_d = ({bus.in_byte, cnt_q[7:0]} != 16'd0) ? S_DATA : S_CSUM;
            S_DATA:   if (accept && idx_q == LAST_IDX) state_d = S_WRITE;
            S_WRITE:  state_d = (cnt_q > 16'd1) ? S_DATA : S_CSUM;
            S_CSUM:   if (accept) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // datapath: header capture, running checksum, group assembly and the registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            adr_lo_q     <= '0;
            adr_q        <= '0;
            cnt_q        <= '0;
            csum_q       <= '0;
            idx_q        <= '0;
            asm_q        <= '0;
            write_adr_q  <= '0;
            write_q      <= 1'b0;
            write_data_q <= '0;
            error_q      <= 1'b0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && bus.in_byte == sync_byte) begin
                        csum_q  <= '0;
                        error_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                S_ADR_LO: begin
                    if (accept) begin
                        adr_lo_q <= bus.in_byte;
                        csum_q   <= csum_q ^ bus.in_byte;
                    end
                end
                S_ADR_HI: begin
                    if (accept) begin
                        adr_q  <= i_adr_width'({bus.in_byte, adr_lo_q});
                        csum_q <= csum_q ^ bus.in_byte;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        cnt_q[7:0] <= bus.in_byte;
                        csum_q     <= csum_q ^ bus.in_byte;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        cnt_q[15:8] <= bus.in_byte;
                        csum_q      <= csum_q ^ bus.in_byte;
                        idx_q       <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_q  <= asm_d;
                        csum_q <= csum_q ^ bus.in_byte;
                        if (idx_q == LAST_IDX) begin
                            // bits of the last byte above W fall off in the cast
                            idx_q        <= '0;
                            write_q      <= 1'b1;
                            write_data_q <= W'(asm_d);
                            write_adr_q  <= adr_q;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // address wraps naturally at 2^i_adr_width
                    adr_q <= adr_q + 1'b1;
                    cnt_q <= cnt_q - 16'd1;
                end
                S_CSUM: begin
                    if (accept) error_q <= (bus.in_byte != csum_q);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader sitting directly upstream of the instruction buffer.
- Accepts framed program images over an 8-bit valid/ready interface and assembles each instruction group (i_buffer_size instructions of i_width bits).
- Drives the buffer's write port (imem_write_adr, imem_write, imem_in) one group per write pulse.
- Checks a frame XOR checksum and reports busy/done/error to the host and to the core's status inputs.

Parameters:
- i_adr_width, 10: instruction-memory write address width; one address per instruction group.
- i_width, 23: single instruction width.
- i_buffer_size, 2: instructions per write group; group width W = i_buffer_size*i_width (46).
- sync_byte, 8'hA5: frame start marker.
- Derived constant (not overridable): BPW = ceil(W/8) = 6, the number of payload bytes per group.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_byte  input  8  host data byte.
- in_valid  input  1  in_byte valid.
- in_ready  output  1  loader can accept a byte; a transfer occurs when in_valid && in_ready on a rising clk edge.
- imem_write_adr  output  i_adr_width  write address to the instruction buffer.
- imem_write  output  1  one-cycle write strobe.
- imem_in  output  W  instruction group data.
- load_busy  output  1  frame in progress.
- load_done  output  1  one-cycle pulse at frame end.
- load_error  output  1  checksum mismatch on the last frame; sticky.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high. On reset:
  - state returns to IDLE.
  - All outputs go to 0: imem_write_adr, imem_in, imem_write, load_busy, load_done, load_error.
  - Internal address, count, checksum and byte index are cleared.
- Frame format (all multi-byte fields little-endian), in order:
  - sync_byte
  - ADR_LO, ADR_HI
  - CNT_LO, CNT_HI
  - CNT groups of BPW bytes each
  - CSUM
- Address field: only the low i_adr_width bits of {ADR_HI,ADR_LO} are used.
- Payload packing: byte k of a group goes to imem_in[8k+7:8k]. Bits of the last byte above W are discarded.
- Checksum: CSUM must equal the XOR of every byte after sync, up to but excluding CSUM.
- States:
  - IDLE: in_ready=1. A byte equal to sync_byte moves to ADR_LO, clears the checksum and clears load_error. Any other byte is accepted and dropped.
  - ADR_LO, ADR_HI, CNT_LO, CNT_HI: accept one byte each and advance. After CNT_HI, go to DATA if the count is non-zero, otherwise go to CSUM.
  - DATA: accept bytes into the assembly register, incrementing the byte index 0..BPW-1. Acceptance of byte BPW-1 moves to WRITE.
  - WRITE: single cycle, in_ready=0.
    - imem_write=1 with imem_in = the assembled group and imem_write_adr = the current address.
    - The address then increments modulo 2^i_adr_width (0x3FF wraps to 0x000) and the count decrements.
    - Next state is DATA if the remaining count is >0, else CSUM.
  - CSUM: accept one byte. load_error <= (byte != running XOR). Go to DONE.
  - DONE: single cycle, in_ready=0, load_done=1. Return to IDLE.
- Output timing:
  - imem_write is registered: it asserts in the cycle after the last payload byte is accepted, for exactly one cycle per group.
  - imem_in and imem_write_adr hold their values after the write until the next write.
- load_busy is 1 in every state except IDLE.
- in_ready is 1 in all states except WRITE and DONE.
- in_valid gaps: any number of idle cycles between bytes is legal. State, byte index and checksum hold while in_valid=0.
- A sync_byte value arriving mid-frame is treated as ordinary data; there is no resynchronisation.
- Writes are not rolled back on checksum failure. The error is only flagged.
- Reset mid-frame: loader returns to IDLE immediately. A partial group is never written.
- The loader never issues two writes in consecutive cycles. Maximum write rate is one per BPW+1 cycles.

Test Plan:
- Basic frame: bytes A5 05 00 01 00 01 02 03 04 05 06 03, in_valid continuous. Required:
  - one imem_write pulse with imem_adr=0x005 and imem_in=46'h060504030201.
  - load_done pulse 1 cycle after CSUM is accepted; load_error=0.
  - load_busy high from ADR_LO until DONE.
- Address wrap: frame at address 0x3FF with CNT=2 and a correct CSUM. Required: writes to 0x3FF then 0x000, with in_ready low exactly in each WRITE cycle.
- Framing and last-byte masking:
  - Garbage bytes 00 FF 5A before A5 are dropped with no write.
  - A last payload byte of FF yields imem_in[45:40]=6'h3F.
- Bad checksum: basic frame with CSUM=00. Required: the write still occurs, load_done pulses, load_error=1 and stays 1 until the next sync byte is accepted.
- Reset mid-frame: assert reset after the 3rd payload byte. Required:
  - no imem_write is issued and all outputs are 0.
  - a following valid frame loads correctly.
- Zero count and gaps:
  - CNT=0 with CSUM=05 (address 0x005): required is no write, load_done pulses, load_error=0.
  - Random in_valid gaps on the basic frame give an identical result.
